// File: rtl/cnn_layer_sequencer_if.sv
// cnn_layer_sequencer_if: Avalon-MM register bus and interrupt line between the HPS and the sequencer.
interface cnn_layer_sequencer_if;
  logic        chipselect, write, read;
  logic [2:0]  address;
  logic [15:0] writedata, readdata;
  logic        irq;
  modport master (output chipselect, write, read, address, writedata, input readdata, irq);
  modport slave  (input chipselect, write, read, address, writedata, output readdata, irq);
endinterface

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: steps the CNN controller through layer codes 1..NUM_LAYERS and reports result, cycles and irq.
module cnn_layer_sequencer #(
  parameter logic [15:0] TIMEOUT_RST = 16'hFFFF,
  parameter int          NUM_LAYERS  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  cnn_layer_sequencer_if.slave  bus,
  output logic [7:0]            state,
  input  logic [7:0]            done,
  input  logic [3:0]            fc_class
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH, S_ERROR} st_t;
  localparam logic [2:0] LAST = 3'(NUM_LAYERS);
  st_t         st_q, st_d;
  logic [2:0]  layer_q, layer_d;
  logic [7:0]  state_q, state_d;
  logic [15:0] tmo_q, tmo_d, limit_q, limit_d, rdata_q, rdata_d, rmux;
  logic [31:0] cyc_q, cyc_d;
  logic [3:0]  class_q, class_d;
  logic        irq_en_q, irq_en_d, fin_q, fin_d, terr_q, terr_d, valid_q, valid_d, irq_q, irq_d;
  logic        wr, ctrl_wr, abort, start, ack, busy;
  assign wr      = bus.chipselect & bus.write;
  assign ctrl_wr = wr & (bus.address == 3'd0);
  assign abort   = ctrl_wr & bus.writedata[1];
  assign start   = ctrl_wr & bus.writedata[0] & ~bus.writedata[1];
  assign ack     = wr & (bus.address == 3'd6);
  assign busy    = st_q != S_IDLE;
  assign state        = state_q;
  assign bus.readdata = rdata_q;
  assign bus.irq      = irq_q;
  always_comb begin
    rmux = 16'h0;
    case (bus.address)
      3'd1: rmux = {9'h0, busy ? layer_q : 3'd0, 1'b0, terr_q, fin_q, busy};
      3'd2: rmux = {valid_q, 11'h0, class_q};
      3'd3: rmux = cyc_q[15:0];
      3'd4: rmux = cyc_q[31:16];
      3'd5: rmux = limit_q;
      default: rmux = 16'h0;
    endcase
  end
  // Status sets from FINISH/ERROR are applied after the ack clear so a coincident set wins.
  always_comb begin
    st_d     = st_q;
    layer_d  = layer_q;
    state_d  = state_q;
    tmo_d    = tmo_q;
    cyc_d    = (busy && cyc_q != 32'hFFFF_FFFF) ? cyc_q + 32'd1 : cyc_q;
    class_d  = class_q;
    valid_d  = valid_q;
    fin_d    = ack ? 1'b0 : fin_q;
    terr_d   = ack ? 1'b0 : terr_q;
    irq_d    = ack ? 1'b0 : irq_q;
    irq_en_d = ctrl_wr ? bus.writedata[2] : irq_en_q;
    limit_d  = (wr && bus.address == 3'd5) ? bus.writedata : limit_q;
    rdata_d  = (bus.chipselect & bus.read) ? rmux : rdata_q;
    if (abort && busy) begin
      st_d    = S_IDLE;
      state_d = 8'h0;
    end else begin
      case (st_q)
        S_IDLE: if (start) begin
          st_d    = S_ISSUE;
          layer_d = 3'd1;
          cyc_d   = 32'h0;
          valid_d = 1'b0;
          fin_d   = 1'b0;
          terr_d  = 1'b0;
        end
        S_ISSUE: begin
          state_d = {5'h0, layer_q};
          tmo_d   = 16'h0;
          st_d    = S_WAIT;
        end
        S_WAIT: begin
          if (tmo_q == limit_q) st_d = S_ERROR;
          else if (done == {5'h0, layer_q}) begin
            st_d    = (layer_q == LAST) ? S_FINISH : S_ISSUE;
            layer_d = (layer_q == LAST) ? layer_q : layer_q + 3'd1;
          end else tmo_d = tmo_q + 16'd1;
        end
        S_FINISH: begin
          class_d = fc_class;
          valid_d = 1'b1;
          fin_d   = 1'b1;
          irq_d   = irq_en_q | irq_d;
          state_d = 8'h0;
          st_d    = S_IDLE;
        end
        S_ERROR: begin
          terr_d  = 1'b1;
          irq_d   = irq_en_q | irq_d;
          state_d = 8'h0;
          st_d    = S_IDLE;
        end
        default: st_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= S_IDLE;
      layer_q  <= 3'd0;
      state_q  <= 8'h0;
      tmo_q    <= 16'h0;
      limit_q  <= TIMEOUT_RST;
      rdata_q  <= 16'h0;
      cyc_q    <= 32'h0;
      class_q  <= 4'h0;
      valid_q  <= 1'b0;
      fin_q    <= 1'b0;
      terr_q   <= 1'b0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      layer_q  <= layer_d;
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      limit_q  <= limit_d;
      rdata_q  <= rdata_d;
      cyc_q    <= cyc_d;
      class_q  <= class_d;
      valid_q  <= valid_d;
      fin_q    <= fin_d;
      terr_q   <= terr_d;
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
    end
  end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed register and layer-handshake checks with hand-computed expectations.
module tb_cnn_layer_sequencer;
  logic       clk, reset;
  logic [7:0] state, done;
  logic [3:0] fc_class;
  logic [15:0] rv;
  int checks, errors;
  cnn_layer_sequencer_if bus ();
  cnn_layer_sequencer dut (.clk(clk), .reset(reset), .bus(bus), .state(state), .done(done), .fc_class(fc_class));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    tick;
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    tick;
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask
  task automatic echo(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      chk($sformatf("state_l%0d", k), {24'h0, state}, k);
      tick;
      tick;
      done = 8'(k);
      tick;
      tick;
    end
  endtask
  task automatic rd_all(input string tag);
    logic [15:0] exp [0:7];
    exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0};
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rv);
      chk($sformatf("%s_reg%0d", tag, a), {16'h0, rv}, {16'h0, exp[a]});
    end
  endtask
  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; done = 8'h0; fc_class = 4'd7;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.address = 3'd0; bus.writedata = 16'h0;
    tick; tick;
    reset = 1'b0;
    chk("rst_state", {24'h0, state}, 0);
    chk("rst_irq", {31'h0, bus.irq}, 0);
    rd_all("rst");
    wr(3'd0, 16'd5);
    chk("start_lat0", {24'h0, state}, 0);
    tick;
    echo(1, 6);
    chk("fin_state", {24'h0, state}, 0);
    chk("fin_irq", {31'h0, bus.irq}, 1);
    done = 8'h0;
    rd(3'd2, rv); chk("fin_result", {16'h0, rv}, 32'h8007);
    rd(3'd1, rv); chk("fin_status", {16'h0, rv}, 32'h0002);
    rd(3'd3, rv); chk("fin_cyc_lo", {16'h0, rv}, 25);
    rd(3'd4, rv); chk("fin_cyc_hi", {16'h0, rv}, 0);
    wr(3'd6, 16'h0);
    chk("ack_irq", {31'h0, bus.irq}, 0);
    rd(3'd1, rv); chk("ack_status", {16'h0, rv}, 0);
    wr(3'd5, 16'd10);
    rd(3'd5, rv); chk("tmo_reg", {16'h0, rv}, 10);
    wr(3'd0, 16'd1);
    tick;
    echo(1, 2);
    chk("tmo_l3", {24'h0, state}, 3);
    for (int i = 0; i < 11; i++) tick;
    chk("tmo_hold", {24'h0, state}, 3);
    tick;
    chk("tmo_state", {24'h0, state}, 0);
    chk("tmo_noirq", {31'h0, bus.irq}, 0);
    done = 8'h0;
    rd(3'd1, rv); chk("tmo_status", {16'h0, rv}, 32'h0004);
    rd(3'd2, rv); chk("tmo_result", {16'h0, rv}, 32'h0007);
    wr(3'd5, 16'd0);
    wr(3'd0, 16'd5);
    tick;
    chk("tmo0_l1", {24'h0, state}, 1);
    tick;
    chk("tmo0_hold", {24'h0, state}, 1);
    tick;
    chk("tmo0_state", {24'h0, state}, 0);
    chk("tmo0_irq", {31'h0, bus.irq}, 1);
    rd(3'd1, rv); chk("tmo0_status", {16'h0, rv}, 32'h0004);
    wr(3'd6, 16'h0);
    wr(3'd5, 16'hFFFF);
    wr(3'd0, 16'd1);
    tick;
    echo(1, 3);
    chk("abt_l4", {24'h0, state}, 4);
    tick; tick;
    done = 8'd4;
    wr(3'd0, 16'd2);
    chk("abt_state", {24'h0, state}, 0);
    tick; tick;
    chk("abt_noadv", {24'h0, state}, 0);
    chk("abt_noirq", {31'h0, bus.irq}, 0);
    done = 8'h0;
    rd(3'd1, rv); chk("abt_status", {16'h0, rv}, 0);
    rd(3'd2, rv); chk("abt_result", {16'h0, rv}, 32'h0007);
    wr(3'd0, 16'd1);
    tick;
    echo(1, 1);
    chk("busy_l2", {24'h0, state}, 2);
    done = 8'd5;
    wr(3'd0, 16'd1);
    tick;
    rd(3'd3, rv); chk("busy_cyc", {16'h0, rv}, 7);
    chk("busy_norestart", {24'h0, state}, 2);
    rd(3'd1, rv); chk("busy_status", {16'h0, rv}, 32'h0021);
    done = 8'd2;
    tick; tick;
    chk("busy_l3", {24'h0, state}, 3);
    echo(3, 4);
    chk("rst_l5", {24'h0, state}, 5);
    tick;
    reset = 1'b1;
    tick;
    chk("midrst_state", {24'h0, state}, 0);
    chk("midrst_irq", {31'h0, bus.irq}, 0);
    reset = 1'b0;
    done = 8'h0;
    rd_all("midrst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
